vid_fx_ctrl: RTL and testbench

Timing and control sequencer for the pixel-effect datapath. It derives pixel/line coordinates from the incoming vid_io sync/VDE strobes and drives the two row line-buffer BRAMs (write enable, write address, read-ahead address). It also decides when the 3x3 window is valid, debounces the user buttons into a saturating brightness factor, and applies the switch-selected effect mode only on frame boundaries. It sits beside the effect datapath; the datapath consumes its outputs and delays pixel data by one register to align with them.

---
 rtl/vid_fx_ctrl.sv | 250 +++++++++++++++++++++++++
 tb/tb_vid_fx_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/vid_fx_ctrl.sv
// rtl/vid_fx_ctrl.sv - Timing/control sequencer for the pixel-effect datapath (optional: VID_FX_CTRL_AUTOCYCLE_EN)
module vid_fx_ctrl #(
    parameter int LINE_WIDTH  = 1920,
    parameter int ADDR_WIDTH  = 11,
    parameter int RD_LEAD     = 2,
    parameter int DB_CYCLES   = 1000000,
    parameter int BRIGHT_DEF  = 100,
    parameter int BRIGHT_STEP = 5,
    parameter int BRIGHT_MIN  = 10,
`ifdef VID_FX_CTRL_AUTOCYCLE_EN
    parameter int BRIGHT_MAX  = 200,
    parameter int AUTO_FRAMES = 60
`else
    parameter int BRIGHT_MAX  = 200
`endif
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  i_vid_hsync,
    input  logic                  i_vid_vsync,
    input  logic                  i_vid_VDE,
    input  logic [3:0]            sw,
    input  logic [3:0]            btn,
    output logic [3:0]            o_mode,
    output logic [7:0]            o_bright,
    output logic                  o_lb_we,
    output logic [ADDR_WIDTH-1:0] o_lb_wr_addr,
    output logic [ADDR_WIDTH-1:0] o_lb_rd_addr,
    output logic [ADDR_WIDTH-1:0] o_x,
    output logic [10:0]           o_y,
    output logic                  o_win_valid,
    output logic                  o_frame_start,
    output logic                  o_overrun
);

    typedef enum logic [1:0] {S_WAIT, S_VBLANK, S_ACTIVE, S_HBLANK} state_t;

    localparam int DBW = $clog2(DB_CYCLES) + 1;

    state_t state, state_nx;
    logic   vs_d, de_d;
    logic   vs_rise, de_rise, de_fall;
    logic   pix, first_pix, line_end;
    logic   we_nx, ovr_set;
    logic [ADDR_WIDTH-1:0] x_nx, rd_nx;
    logic [ADDR_WIDTH:0]   rd_sum;
    logic [10:0]           y_nx;

    logic [2:0]     btn_s1, btn_s2, db_lvl, db_lvl_d, press;
    logic [DBW-1:0] db_cnt [3];
    logic [7:0]     bright_q, bright_nx;
    logic [8:0]     bright_dn, bright_up;

    // hsync carries no information beyond the VDE edges; btn[3] has no function
    logic unused_inputs;
    assign unused_inputs = i_vid_hsync ^ btn[3];

    assign vs_rise = i_vid_vsync & ~vs_d;
    assign de_rise = i_vid_VDE & ~de_d;
    assign de_fall = ~i_vid_VDE & de_d;

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state <= S_WAIT;
            vs_d  <= 1'b0;
            de_d  <= 1'b0;
        end else begin
            state <= state_nx;
            vs_d  <= i_vid_vsync;
            de_d  <= i_vid_VDE;
        end
    end

    always_comb begin
        state_nx = state;
        pix      = 1'b0;
        line_end = 1'b0;
        if (vs_rise) begin
            state_nx = S_VBLANK;
        end else begin
            case (state)
                S_VBLANK, S_HBLANK: begin
                    if (de_rise) begin
                        state_nx = S_ACTIVE;
                        pix      = 1'b1;
                    end
                end
                S_ACTIVE: begin
                    if (de_fall) begin
                        state_nx = S_HBLANK;
                        line_end = 1'b1;
                    end else if (i_vid_VDE) begin
                        pix = 1'b1;
                    end
                end
                default: state_nx = state;
            endcase
        end
    end

    assign first_pix = pix && (state != S_ACTIVE);

    // Column stops at the last buffer slot; further pixels are dropped and flagged
    always_comb begin
        x_nx    = o_x;
        we_nx   = 1'b0;
        ovr_set = 1'b0;
        if (vs_rise || line_end) begin
            x_nx = '0;
        end else if (pix) begin
            if (first_pix) begin
                x_nx  = '0;
                we_nx = 1'b1;
            end else if (o_x == ADDR_WIDTH'(LINE_WIDTH - 1)) begin
                ovr_set = 1'b1;
            end else begin
                x_nx  = o_x + 1'b1;
                we_nx = 1'b1;
            end
        end
    end

    always_comb begin
        y_nx = o_y;
        if (vs_rise)
            y_nx = '0;
        else if (line_end && (o_y != 11'd2047))
            y_nx = o_y + 11'd1;
    end

    assign rd_sum = {1'b0, x_nx} + (ADDR_WIDTH + 1)'(RD_LEAD);
    assign rd_nx  = (rd_sum >= (ADDR_WIDTH + 1)'(LINE_WIDTH))
                  ? ADDR_WIDTH'(rd_sum - (ADDR_WIDTH + 1)'(LINE_WIDTH))
                  : rd_sum[ADDR_WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            o_x           <= '0;
            o_y           <= '0;
            o_lb_we       <= 1'b0;
            o_lb_wr_addr  <= '0;
            o_lb_rd_addr  <= '0;
            o_win_valid   <= 1'b0;
            o_frame_start <= 1'b0;
            o_overrun     <= 1'b0;
            o_bright      <= 8'(BRIGHT_DEF);
        end else begin
            o_x           <= x_nx;
            o_y           <= y_nx;
            o_lb_we       <= we_nx;
            o_lb_wr_addr  <= x_nx;
            o_lb_rd_addr  <= rd_nx;
            o_win_valid   <= we_nx && (o_y >= 11'd2) && (x_nx >= ADDR_WIDTH'(2));
            o_frame_start <= vs_rise;
            if (vs_rise)
                o_overrun <= 1'b0;
            else if (ovr_set)
                o_overrun <= 1'b1;
            if (vs_rise)
                o_bright <= bright_q;
        end
    end

`ifdef VID_FX_CTRL_AUTOCYCLE_EN
    localparam int FCW = $clog2(AUTO_FRAMES + 1);

    logic [FCW-1:0] fr_cnt;
    logic           auto_on;

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            o_mode  <= '0;
            fr_cnt  <= '0;
            auto_on <= 1'b0;
        end else if (vs_rise) begin
            if (sw == 4'b1111) begin
                if (!auto_on) begin
                    auto_on <= 1'b1;
                    fr_cnt  <= '0;
                    o_mode  <= 4'd1;
                end else if (fr_cnt == FCW'(AUTO_FRAMES - 1)) begin
                    fr_cnt <= '0;
                    o_mode <= (o_mode == 4'd12) ? 4'd1 : o_mode + 4'd1;
                end else begin
                    fr_cnt <= fr_cnt + 1'b1;
                end
            end else begin
                auto_on <= 1'b0;
                fr_cnt  <= '0;
                o_mode  <= sw;
            end
        end
    end
`else
    always_ff @(posedge clk) begin
        if (!n_rst)
            o_mode <= '0;
        else if (vs_rise)
            o_mode <= sw;
    end
`endif

    // A level is accepted once the synchronised input has disagreed for DB_CYCLES samples in a row
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            btn_s1   <= '0;
            btn_s2   <= '0;
            db_lvl   <= '0;
            db_lvl_d <= '0;
            for (int i = 0; i < 3; i++)
                db_cnt[i] <= '0;
        end else begin
            btn_s1   <= btn[2:0];
            btn_s2   <= btn_s1;
            db_lvl_d <= db_lvl;
            for (int i = 0; i < 3; i++) begin
                if (btn_s2[i] == db_lvl[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DBW'(DB_CYCLES - 1)) begin
                    db_cnt[i] <= '0;
                    db_lvl[i] <= btn_s2[i];
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign press     = db_lvl & ~db_lvl_d;
    assign bright_dn = {1'b0, bright_q} - 9'(BRIGHT_STEP);
    assign bright_up = {1'b0, bright_q} + 9'(BRIGHT_STEP);

    always_comb begin
        bright_nx = bright_q;
        if (press[0])
            bright_nx = 8'(BRIGHT_DEF);
        else if (press[1])
            bright_nx = (bright_dn[8] || (bright_dn < 9'(BRIGHT_MIN))) ? 8'(BRIGHT_MIN) : bright_dn[7:0];
        else if (press[2])
            bright_nx = (bright_up > 9'(BRIGHT_MAX)) ? 8'(BRIGHT_MAX) : bright_up[7:0];
    end

    always_ff @(posedge clk) begin
        if (!n_rst)
            bright_q <= 8'(BRIGHT_DEF);
        else
            bright_q <= bright_nx;
    end

endmodule

// File: tb/tb_vid_fx_ctrl.sv
// tb/tb_vid_fx_ctrl.sv - Self-checking bench for vid_fx_ctrl with a behavioural reference model
module tb_vid_fx_ctrl;

    localparam int LW   = 8;
    localparam int AW   = 4;
    localparam int LEAD = 2;
    localparam int DBC  = 4;

    logic          clk = 1'b0;
    logic          n_rst, hs, vs, de;
    logic [3:0]    sw, btn;
    logic [3:0]    o_mode;
    logic [7:0]    o_bright;
    logic          o_lb_we, o_win_valid, o_frame_start, o_overrun;
    logic [AW-1:0] o_lb_wr_addr, o_lb_rd_addr, o_x;
    logic [10:0]   o_y;

    int total = 0;
    int bad   = 0;
    int y_m, bright_m, mode_m, win_cnt;
    bit ovr_m;

    vid_fx_ctrl #(
        .LINE_WIDTH(LW), .ADDR_WIDTH(AW), .RD_LEAD(LEAD), .DB_CYCLES(DBC)
    ) dut (
        .clk(clk), .n_rst(n_rst), .i_vid_hsync(hs), .i_vid_vsync(vs), .i_vid_VDE(de),
        .sw(sw), .btn(btn), .o_mode(o_mode), .o_bright(o_bright), .o_lb_we(o_lb_we),
        .o_lb_wr_addr(o_lb_wr_addr), .o_lb_rd_addr(o_lb_rd_addr), .o_x(o_x), .o_y(o_y),
        .o_win_valid(o_win_valid), .o_frame_start(o_frame_start), .o_overrun(o_overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            step();
            chk("idle_we", 32'(o_lb_we), 0);
            chk("idle_win", 32'(o_win_valid), 0);
        end
    endtask

    task automatic frame();
        mode_m = int'(sw);
        vs = 1'b1;
        step();
        chk("fs_pulse", 32'(o_frame_start), 1);
        chk("fs_x", 32'(o_x), 0);
        chk("fs_y", 32'(o_y), 0);
        chk("fs_ovr", 32'(o_overrun), 0);
        chk("fs_mode", 32'(o_mode), 32'(mode_m));
        chk("fs_bright", 32'(o_bright), 32'(bright_m));
        step();
        chk("fs_once", 32'(o_frame_start), 0);
        vs = 1'b0;
        idle(2);
        y_m   = 0;
        ovr_m = 1'b0;
    endtask

    task automatic line(input int len);
        int ex_x;
        bit ex_we;
        for (int i = 0; i < len; i++) begin
            de = 1'b1;
            step();
            ex_x  = (i < LW) ? i : LW - 1;
            ex_we = (i < LW);
            if (i >= LW) ovr_m = 1'b1;
            chk("px_x", 32'(o_x), 32'(ex_x));
            chk("px_wr", 32'(o_lb_wr_addr), 32'(ex_x));
            chk("px_rd", 32'(o_lb_rd_addr), 32'((ex_x + LEAD) % LW));
            chk("px_we", 32'(o_lb_we), 32'(ex_we));
            chk("px_win", 32'(o_win_valid), 32'(ex_we && y_m >= 2 && ex_x >= 2));
            chk("px_y", 32'(o_y), 32'(y_m));
            chk("px_ovr", 32'(o_overrun), 32'(ovr_m));
            chk("px_mode", 32'(o_mode), 32'(mode_m));
            if (o_win_valid) win_cnt++;
        end
        de = 1'b0;
        step();
        y_m = (y_m < 2047) ? y_m + 1 : 2047;
        chk("eol_x", 32'(o_x), 0);
        chk("eol_we", 32'(o_lb_we), 0);
        chk("eol_y", 32'(o_y), 32'(y_m));
        hs = 1'b1;
        idle(1);
        hs = 1'b0;
        idle($urandom_range(0, 3));
    endtask

    task automatic press(input logic [3:0] b);
        btn = b;
        repeat (10) step();
        btn = 4'b0;
        repeat (10) step();
        if (b[0])      bright_m = 100;
        else if (b[1]) bright_m = (bright_m - 5 < 10) ? 10 : bright_m - 5;
        else if (b[2]) bright_m = (bright_m + 5 > 200) ? 200 : bright_m + 5;
    endtask

    initial begin
        n_rst = 1'b0; hs = 1'b0; vs = 1'b0; de = 1'b0; sw = 4'b0; btn = 4'b0;
        y_m = 0; bright_m = 100; mode_m = 0; win_cnt = 0; ovr_m = 1'b0;
        repeat (3) step();
        chk("rst_mode", 32'(o_mode), 0);
        chk("rst_bright", 32'(o_bright), 100);
        chk("rst_we", 32'(o_lb_we), 0);
        chk("rst_x", 32'(o_x), 0);
        chk("rst_y", 32'(o_y), 0);
        chk("rst_ovr", 32'(o_overrun), 0);
        chk("rst_fs", 32'(o_frame_start), 0);
        n_rst = 1'b1;

        for (int p = 0; p < 3; p++) begin
            de = 1'b1;
            step();
            chk("prevs_we", 32'(o_lb_we), 0);
            de = 1'b0;
            idle(2);
        end
        chk("prevs_mode", 32'(o_mode), 0);
        chk("prevs_bright", 32'(o_bright), 100);

        sw = 4'b0001;
        frame();
        win_cnt = 0;
        for (int l = 0; l < 4; l++) begin
            line(8);
            if (l == 1) sw = 4'b0010;
        end
        chk("win_total", 32'(win_cnt), 12);
        frame();

        line(10);
        chk("ovr_sticky", 32'(o_overrun), 1);
        line(LW);
        chk("ovr_hold", 32'(o_overrun), 1);
        frame();

        btn = 4'b0100;
        step(); step();
        btn = 4'b0;
        repeat (12) step();
        frame();
        for (int k = 0; k < 3; k++) press(4'b0100);
        frame();
        chk("bright_115", 32'(o_bright), 115);
        btn = 4'b0010;
        repeat (50) step();
        btn = 4'b0;
        repeat (12) step();
        bright_m = bright_m - 5;
        frame();
        for (int k = 0; k < 25; k++) press(4'b0010);
        frame();
        for (int k = 0; k < 45; k++) press(4'b0100);
        frame();
        for (int k = 0; k < 24; k++) begin
            press(4'($urandom_range(1, 7)));
            if (k % 6 == 5) begin
                sw = 4'($urandom_range(0, 14));
                frame();
                line($urandom_range(3, 10));
            end
        end
`ifndef VID_FX_CTRL_AUTOCYCLE_EN
        sw = 4'b1111;
        frame();
`endif

        sw = 4'b0101;
        frame();
        de = 1'b1;
        repeat (3) step();
        n_rst = 1'b0;
        step();
        n_rst = 1'b1;
        bright_m = 100;
        chk("mid_rst_we", 32'(o_lb_we), 0);
        chk("mid_rst_x", 32'(o_x), 0);
        chk("mid_rst_mode", 32'(o_mode), 0);
        chk("mid_rst_bright", 32'(o_bright), 100);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("post_rst_we", 32'(o_lb_we), 0);
        end
        de = 1'b0;
        idle(2);
        for (int l = 0; l < 2; l++) begin
            de = 1'b1;
            for (int k = 0; k < LW; k++) begin
                step();
                chk("post_rst_line_we", 32'(o_lb_we), 0);
            end
            de = 1'b0;
            idle(2);
        end
        sw = 4'b0011;
        frame();
        line(LW);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
